// File: rtl/sp_ram_ctrl_if.sv
// Request/response bus for the single-port RAM controller.
// The master issues read/write requests and consumes read responses;
// the slave (the controller) accepts requests and presents responses.
interface sp_ram_ctrl_if #(
    parameter int DATA_W = 50,
    parameter int ADDR_W = 9
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/sp_ram_ctrl.sv
// Single-port RAM controller: one read or write per cycle through a
// valid/ready request channel, registered read responses with
// backpressure, and a sequenced full-array clear.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | accepting requests (unless a response is stalled)
// CLEAR | writing CLR_VAL to one address per cycle, requests blocked
module sp_ram_ctrl #(
    parameter int                 DATA_W  = 50,
    parameter int                 ADDR_W  = 9,
    parameter int                 DEPTH   = 512,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    sp_ram_ctrl_if.slave      bus,
    input  logic              clr_start,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic              run_q;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_last;
    logic              acc;
    logic              in_range;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // run_q holds req_ready low while reset is asserted and releases it
    // on the first clock edge afterwards.
    assign in_range      = {1'b0, bus.req_addr} < DEPTH_EXT;
    assign bus.req_ready = run_q && (state == IDLE) && !(rsp_valid_q && !bus.rsp_ready);
    assign acc           = bus.req_valid && bus.req_ready;
    assign clr_last      = (clr_cnt == LAST_ADDR);
    assign busy          = (state == CLEAR);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    // State register and post-reset run flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            run_q <= 1'b0;
        end else begin
            state <= state_nxt;
            run_q <= 1'b1;
        end
    end

    // Next-state logic: clr_start only matters in IDLE, so a pulse during
    // CLEAR cannot restart the sweep.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_start) state_nxt = CLEAR;
            CLEAR:   if (clr_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Clear address counter: sweeps 0..DEPTH-1, wraps to 0 on the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
        end
    end

    // Storage array (not reset). Clear writes and request writes are
    // mutually exclusive because req_ready is low in CLEAR.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= CLR_VAL;
        end else if (acc && bus.req_we && in_range) begin
            mem[bus.req_addr] <= bus.req_wdata;
        end
    end

    // Read response register: loads on an accepted read, holds while
    // stalled, drops after the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else if (acc && !bus.req_we) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !in_range;
            rsp_data_q  <= in_range ? mem[bus.req_addr] : '0;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed bench for sp_ram_ctrl with DEPTH=300 (address space 512).
module tb_sp_ram_ctrl;

    localparam int          DW    = 50;
    localparam int          AW    = 9;
    localparam int          DEP   = 300;
    localparam logic [49:0] CLR   = 50'h1_DEAD_BEEF_0C1E;

    logic clk = 1'b0;
    logic rst_n;
    logic clr_start;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;

    sp_ram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sp_ram_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEP),
        .CLR_VAL(CLR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .clr_start(clr_start),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [49:0] pat(input int a);
        return 50'h2_5A5A_0000_0000 ^ 50'(a * 7919 + 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [49:0] obs, input logic [49:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int a, input logic [49:0] d);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = AW'(a);
        bus.req_wdata = d;
        tick();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic do_read(input string tag, input int a, input logic [49:0] d, input logic e);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = AW'(a);
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk1({tag, "_valid"}, bus.rsp_valid, 1'b1);
        chkd({tag, "_data"},  bus.rsp_data,  d);
        chk1({tag, "_err"},   bus.rsp_err,   e);
    endtask

    task automatic fill();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        for (int a = 0; a < DEP; a++) begin
            bus.req_addr  = AW'(a);
            bus.req_wdata = pat(a);
            tick();
        end
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    initial begin
        int nbusy;
        int guard;
        int bad;

        rst_n         = 1'b0;
        clr_start     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        #1;
        chk1("rst_req_ready", bus.req_ready, 1'b0);
        chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chkd("rst_rsp_data",  bus.rsp_data,  50'h0);
        chk1("rst_rsp_err",   bus.rsp_err,   1'b0);
        chk1("rst_busy",      busy,          1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk1("pre_edge_req_ready", bus.req_ready, 1'b0);
        tick();
        chk1("first_edge_req_ready", bus.req_ready, 1'b1);

        // write/read, then read-after-write
        do_write(0, 50'h1);
        do_read("rd0_a", 0, 50'h1, 1'b0);
        do_write(0, 50'h2);
        do_read("rd0_b", 0, 50'h2, 1'b0);
        tick();
        chk1("rsp_drop", bus.rsp_valid, 1'b0);

        // backpressure
        do_write(5, 50'h0_1234_5678_9ABC);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = AW'(5);
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1("stall_valid", bus.rsp_valid, 1'b1);
            chkd("stall_data",  bus.rsp_data,  50'h0_1234_5678_9ABC);
            chk1("stall_ready", bus.req_ready, 1'b0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk1("unstall_ready", bus.req_ready, 1'b1);
        tick();
        chk1("unstall_drop", bus.rsp_valid, 1'b0);

        // out-of-range accesses
        do_write(299, 50'h0_0000_0029_9299);
        do_write(400, 50'h3_FFFF_FFFF_FFFF);
        do_read("oor400", 400, 50'h0, 1'b1);
        do_read("top299", 299, 50'h0_0000_0029_9299, 1'b0);

        // 16 back-to-back reads
        for (int i = 0; i < 16; i++) do_write(16 + i, pat(1000 + i));
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.req_addr = AW'(16 + i);
            tick();
            chk1("b2b_valid", bus.rsp_valid, 1'b1);
            chkd("b2b_data",  bus.rsp_data,  pat(1000 + i));
        end
        bus.req_valid = 1'b0;
        tick();
        chk1("b2b_drop", bus.rsp_valid, 1'b0);

        // full clear with a read accepted on the clr_start cycle and held
        fill();
        clr_start     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = AW'(7);
        bus.rsp_ready = 1'b0;
        tick();
        clr_start     = 1'b0;
        bus.req_valid = 1'b0;
        chk1("clr_busy_on",   busy,          1'b1);
        chk1("clr_rsp_valid", bus.rsp_valid, 1'b1);
        chkd("clr_rsp_data",  bus.rsp_data,  pat(7));
        nbusy = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 1000) begin
            nbusy++;
            if (nbusy == 4) begin
                chk1("clr_hold_valid", bus.rsp_valid, 1'b1);
                chkd("clr_hold_data",  bus.rsp_data,  pat(7));
                bus.rsp_ready = 1'b1;
            end
            if (nbusy == 150) begin
                chk1("clr_req_ready", bus.req_ready, 1'b0);
                clr_start = 1'b1;
            end else begin
                clr_start = 1'b0;
            end
            tick();
            guard++;
        end
        clr_start = 1'b0;
        chki("clr_busy_cycles", nbusy, DEP);
        bad = 0;
        for (int a = 0; a < DEP; a++) begin
            do_read("clr_rd", a, CLR, 1'b0);
        end

        // reset at clear count 100 with a stalled response pending
        fill();
        clr_start     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = AW'(250);
        bus.rsp_ready = 1'b0;
        tick();
        clr_start     = 1'b0;
        bus.req_valid = 1'b0;
        repeat (100) tick();
        chk1("abort_busy_pre", busy, 1'b1);
        chk1("abort_rsp_pre",  bus.rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("abort_busy",      busy,          1'b0);
        chk1("abort_req_ready", bus.req_ready, 1'b0);
        chk1("abort_rsp_valid", bus.rsp_valid, 1'b0);
        chkd("abort_rsp_data",  bus.rsp_data,  50'h0);
        chk1("abort_rsp_err",   bus.rsp_err,   1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        tick();
        chk1("abort_rsp_gone", bus.rsp_valid, 1'b0);
        for (int a = 0; a < DEP; a++) begin
            if (a < 100) do_read("part_clr", a, CLR, 1'b0);
            else         do_read("part_old", a, pat(a), 1'b0);
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
